// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the 8-digit seven-segment display path.
package seven_seg_pkg;
  localparam int NUM_DIGITS = 8;

  typedef logic [3:0] digit_t;
  typedef logic [6:0] seg_t;

  localparam seg_t                  SEG_BLANK = 7'h7F;
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 8'hFF;
endpackage

// File: rtl/hex_to_seg.sv
// Hex digit to active-low {g,f,e,d,c,b,a} cathode pattern; combinational, zero latency, no flow control.
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit_t'(digit))
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexes eight snapshotted hex digits onto a common-anode display; outputs registered (1 cycle), no backpressure.
// Optional leading-zero blanking via SEVEN_SEG_LEADING_ZERO_BLANK_EN.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int TICKS_PER_DIGIT = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] d7,
  input  logic [3:0] d6,
  input  logic [3:0] d5,
  input  logic [3:0] d4,
  input  logic [3:0] d3,
  input  logic [3:0] d2,
  input  logic [3:0] d1,
  input  logic [3:0] d0,
  input  logic [7:0] dp_mask,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int               CNT_W     = $clog2(TICKS_PER_DIGIT);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICKS_PER_DIGIT - 1);

  logic [CNT_W-1:0]        prescaler;
  logic [2:0]              idx;
  digit_t [NUM_DIGITS-1:0] snap;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic                    tick;
  logic                    capture;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    show;
  seg_t                    cur_seg;

  assign tick    = (prescaler == TICK_LAST);
  assign capture = tick && (idx == 3'd7);

  always_ff @(posedge clk) begin
    if (!rst) begin
      prescaler <= '0;
      idx       <= '0;
      snap      <= '0;
      snap_dp   <= '0;
    end else begin
      prescaler <= tick ? '0 : prescaler + CNT_W'(1);
      if (tick) idx <= idx + 3'd1;
      // Capture lands on the same edge idx wraps to 0, so a frame never mixes old and new digits.
      if (capture) begin
        snap    <= {d7, d6, d5, d4, d3, d2, d1, d0};
        snap_dp <= dp_mask;
      end
    end
  end

  hex_to_seg u_hex_to_seg (
    .digit (snap[idx]),
    .seg   (cur_seg)
  );

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  logic zeros_above;

  always_comb begin
    blank       = '0;
    zeros_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zeros_above = zeros_above && (snap[i] == '0);
      blank[i]    = zeros_above;
    end
  end
`else
  assign blank = '0;
`endif

  assign show = en && !blank[idx];

  always_ff @(posedge clk) begin
    if (!rst) begin
      an  <= ANODE_OFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= show ? ~(NUM_DIGITS'(1) << idx) : ANODE_OFF;
      seg <= show ? cur_seg : SEG_BLANK;
      dp  <= show ? ~snap_dp[idx] : 1'b1;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: directed frame checks plus randomized traffic against a time-based model.
`timescale 1ns/1ps
module tb_seven_seg_scanner;

  localparam int TPD   = 4;
  localparam int FRAME = 8 * TPD;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic [3:0] d [8];
  logic [7:0] dp_mask;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seven_seg_scanner #(.TICKS_PER_DIGIT(TPD)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .d7      (d[7]),
    .d6      (d[6]),
    .d5      (d[5]),
    .d4      (d[4]),
    .d3      (d[3]),
    .d2      (d[2]),
    .d1      (d[1]),
    .d0      (d[0]),
    .dp_mask (dp_mask),
    .an      (an),
    .seg     (seg),
    .dp      (dp)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  // Model: time since reset release decides the lit digit; snapshot taken at each frame's last cycle.
  int unsigned t;
  logic [3:0]  m_snap [8];
  logic [7:0]  m_dp;
  logic [7:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  bit          mv = 0;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  int          hi;
`endif

  task automatic model_step();
    int k;
    bit lit;
    if (!rst) begin
      t = 0;
      for (int j = 0; j < 8; j++) m_snap[j] = 4'h0;
      m_dp  = 8'h00;
      e_an  = 8'hFF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
      mv    = 1;
    end else begin
      k   = int'((t / TPD) % 8);
      lit = en;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
      hi = 0;
      for (int j = 0; j < 8; j++) if (m_snap[j] != 4'h0) hi = j;
      if (k > hi) lit = 0;
`endif
      e_an  = lit ? ~(8'd1 << k) : 8'hFF;
      e_seg = lit ? ref_seg(m_snap[k]) : 7'h7F;
      e_dp  = lit ? ~m_dp[k] : 1'b1;
      if (t % FRAME == FRAME - 1) begin
        for (int j = 0; j < 8; j++) m_snap[j] = d[j];
        m_dp = dp_mask;
      end
      t++;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (mv) begin
      chk("model_an", an, e_an);
      chk("model_seg", seg, e_seg);
      chk("model_dp", dp, e_dp);
    end
  end

  // Directed stimulus and literal expectations.
  int         c    = 0;
  int         base = 0;
  logic [7:0] an_seq [8];

  function automatic int kpos();
    return ((c - base - 1) / TPD) % 8;
  endfunction

  task automatic step();
    @(negedge clk);
    c++;
  endtask

  initial begin
    an_seq = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    for (int i = 0; i < 8; i++) d[i] = 4'($urandom);
    dp_mask = 8'($urandom);
    en      = 1'b1;
    rst     = 1'b0;

    repeat (3) begin
      step();
      chk("rst_an", an, 8'hFF);
      chk("rst_seg", seg, 7'h7F);
      chk("rst_dp", dp, 1'b1);
    end

    for (int i = 0; i < 8; i++) d[i] = 4'(i);
    dp_mask = 8'h00;
    rst     = 1'b1;
    base    = c;

    repeat (FRAME) begin
      step();
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
      chk("f1_an", an, (kpos() == 0) ? 8'hFE : 8'hFF);
      chk("f1_seg", seg, (kpos() == 0) ? 7'b1000000 : 7'h7F);
`else
      chk("f1_an", an, an_seq[kpos()]);
      chk("f1_seg", seg, 7'b1000000);
`endif
      chk("f1_dp", dp, 1'b1);
    end

    repeat (FRAME) begin
      step();
      chk("f2_an", an, an_seq[kpos()]);
      if (kpos() == 1) chk("f2_seg_d1", seg, 7'b1111001);
      if (kpos() == 7) chk("f2_seg_d7", seg, 7'b1111000);
    end

    repeat (FRAME) begin
      step();
      if (kpos() == 3) chk("tear_old", seg, 7'b0110000);
      if (kpos() == 1) d[3] = 4'h9;
    end

    dp_mask = 8'h04;
    repeat (FRAME) begin
      step();
      if (kpos() == 3) chk("tear_new", seg, 7'b0010000);
      chk("dp_before", dp, 1'b1);
    end

    repeat (FRAME) begin
      step();
      chk("dp_frame", dp, (kpos() == 2) ? 1'b0 : 1'b1);
      chk("dp_an", an, an_seq[kpos()]);
    end

    repeat (10) step();
    en = 1'b0;
    repeat (10) begin
      step();
      chk("en_off_an", an, 8'hFF);
      chk("en_off_seg", seg, 7'h7F);
    end
    en = 1'b1;
    step();
    chk("en_resume_an", an, 8'hDF);
    repeat (11) step();

    repeat (8) step();
    rst = 1'b0;
    step();
    chk("midrst_an", an, 8'hFF);
    chk("midrst_seg", seg, 7'h7F);
    chk("midrst_dp", dp, 1'b1);
    rst  = 1'b1;
    base = c;
    for (int i = 0; i < 8; i++) d[i] = 4'h0;
    d[3] = 4'h1; d[2] = 4'h2; d[1] = 4'h3;
    dp_mask = 8'h00;
    step();
    chk("restart_an", an, 8'hFE);
    chk("restart_seg", seg, 7'b1000000);
    chk("restart_dp", dp, 1'b1);
    repeat (FRAME - 1) step();

    repeat (FRAME) begin
      step();
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
      chk("lzb_upper_an", an[7:4], 4'hF);
      if (kpos() == 0) chk("lzb_d0_seg", seg, 7'b1000000);
`else
      chk("lz_an", an, an_seq[kpos()]);
      if (kpos() == 7) chk("lz_d7_seg", seg, 7'b1000000);
`endif
      if (kpos() == 3) chk("lz_d3_seg", seg, 7'b1111001);
    end

    for (int i = 0; i < 8; i++) d[i] = 4'h0;
    repeat (FRAME) step();
    repeat (FRAME) begin
      step();
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
      chk("allzero_an", an, (kpos() == 0) ? 8'hFE : 8'hFF);
`else
      chk("allzero_an", an, an_seq[kpos()]);
`endif
      if (kpos() == 0) chk("allzero_seg", seg, 7'b1000000);
    end

    repeat (1500) begin
      step();
      if ($urandom_range(15) == 0) d[$urandom_range(7)] = 4'($urandom);
      if ($urandom_range(99) == 0) for (int j = 4; j < 8; j++) d[j] = 4'h0;
      if ($urandom_range(63) == 0) dp_mask = 8'($urandom);
      if ($urandom_range(39) == 0) en = ~en;
      rst = ($urandom_range(299) != 0);
    end
    rst = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Consumer end of the stopwatch digit interface. Takes the eight 4-bit digit buses d7..d0 from the stopwatch and time-multiplexes them onto the board's 8-digit common-anode seven-segment display.
- Sits between the stopwatch core and the FPGA top-level pins.
- Snapshots all eight digits once per scan frame, so a frame never mixes old and new values.

Parameters:
- TICKS_PER_DIGIT, 100_000, clk cycles each digit stays lit (1 ms at 100 MHz); minimum 2; set to 4 in simulation.
- CNT_W, $clog2(TICKS_PER_DIGIT), prescaler width, derived; do not override.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous active-low reset.
- en  in  1  display enable; 0 blanks all digits.
- d7..d0  in  4 each  digit values from the stopwatch; d0 is rightmost.
- dp_mask  in  8  decimal-point request per digit; bit i maps to digit i; 1 = lit.
- an  out  8  anode selects, active-low; an[i] drives digit i.
- seg  out  7  cathodes, active-low, ordered {g,f,e,d,c,b,a}.
- dp  out  1  decimal-point cathode, active-low.

Behaviour:
- Reset (rst==0 at a clk edge):
  - prescaler=0, idx=0, snapshot digits=0, snapshot dp_mask=0.
  - an=8'hFF, seg=7'h7F, dp=1.
- Prescaler:
  - counts 0..TICKS_PER_DIGIT-1, then wraps.
  - tick is asserted when prescaler==TICKS_PER_DIGIT-1.
- Digit index (3 bits):
  - increments on tick; wraps 7->0.
  - scan order is digit0, digit1, ..., digit7.
- Snapshot:
  - on the edge where tick && idx==7, all d7..d0 and dp_mask are captured.
  - the newly captured values are displayed starting with digit0 of the next frame.
  - input changes at any other time have no effect until the next capture.
  - the first frame after reset displays zeros.
- Output register (all outputs registered, 1-cycle latency from idx/en):
  - an = en ? ~(8'b1 << idx) : 8'hFF.
  - seg = en ? decode(snap[idx]) : 7'h7F.
  - dp = en ? ~snap_dp[idx] : 1.
- Decode is full hex:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- en:
  - affects outputs only; prescaler, idx and snapshot keep running while en==0.
  - when en rises, the display resumes at the current idx with no restart.
- Exactly one an bit is low whenever en==1 and reset has been released; no two digits are ever lit together.
- Reset mid-frame: on the next edge the outputs go to their reset values; the frame restarts at idx 0 with zero digits.
- Simultaneous tick and snapshot: the capture and the idx wrap to 0 happen on the same edge. Digit0 in the following output cycle uses the new snapshot.

Optional Feature:
- Macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN.
- When defined:
  - scanning from digit7 downward, every digit equal to 0 that precedes the first nonzero digit is blanked: its an bit stays high, seg=7'h7F, dp=1.
  - digit0 is never blanked.
  - blanking is evaluated on the snapshot, not the live inputs.
  - blanked slots still consume their scan time.
- When undefined: all eight digits are always shown, including leading zeros.

Decomposition:
- Package seven_seg_pkg:
  - NUM_DIGITS=8.
  - typedef logic [3:0] digit_t.
  - typedef logic [6:0] seg_t.
  - SEG_BLANK=7'h7F.
  - ANODE_OFF=8'hFF.
- Sub-module hex_to_seg: purely combinational, digit_t in, seg_t out, holds the 16-entry table above. It is reused by other display users.

Test Plan:
- Reset: hold rst=0 for 3 cycles with random d* and en=1 -> an=8'hFF, seg=7'h7F, dp=1 on every cycle of reset.
- Scan and snapshot timing: TICKS_PER_DIGIT=4, d0..d7=0..7, en=1.
  - an steps FE, FD, FB, F7, EF, DF, BF, 7F, 4 cycles each.
  - frame 1 shows seg=1000000 on all digits.
  - frame 2: at an=FD seg=1111001, at an=7F seg=1111000.
- Tear-free capture: change d3 from 3 to 9 while idx==1 -> seg for an=F7 stays 0110000 in the current frame and becomes 0010000 only in the next frame.
- Enable: drop en for 10 cycles mid-frame -> an=FF and seg=7F from the cycle after en falls. After en rises, an resumes at the idx the free-running counter has reached, with no restart from digit0.
- Decimal point: dp_mask=8'h04 -> dp=0 only while an=FB, from the frame after capture. Reset mid-frame -> next edge gives an=FF, then the scan restarts at FE with zeros.
- SEVEN_SEG_LEADING_ZERO_BLANK_EN defined, d7..d0=0,0,0,0,1,2,3,0:
  - an bits 7..4 never go low.
  - digit0 still shows 1000000.
  - with all digits 0, only digit0 is lit.
